// File: rtl/uart_stress_pkg.sv
// Shared constants for the UART stress loopback generator: state encoding and defaults.
package uart_stress_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_SEND      = 2'd1;
  localparam logic [1:0] ST_WAIT_ECHO = 2'd2;
  localparam logic [1:0] ST_DONE      = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE      = ST_IDLE,
    S_SEND      = ST_SEND,
    S_WAIT_ECHO = ST_WAIT_ECHO,
    S_DONE      = ST_DONE
  } state_t;

  localparam int DEF_COUNT   = 256;
  localparam int DEF_TIMEOUT = 100000;

endpackage

// File: rtl/uart_stress_gen_timer.sv
// Per-byte echo timeout counter; o_expire pulses while enabled at count TIMEOUT-1.
module stress_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int W = $clog2(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  // Combinational so the loss is scored in the same cycle the count reaches LAST.
  assign o_expire = i_en && (r_cnt == LAST);

endmodule

// File: rtl/uart_stress_gen.sv
// Lock-step UART loopback generator/checker: sends an incrementing byte, scores each echo,
// and declares the byte lost after TIMEOUT cycles with no echo.
module uart_stress_gen
  import uart_stress_pkg::*;
#(
  parameter int COUNT   = DEF_COUNT,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             SYSCLK,
  input  logic             SYSRST,
  input  logic             START,
  input  logic             TX_READY,
  output logic             TX_VALID,
  output logic [7:0]       TX_DATA,
  input  logic             RX_VALID,
  input  logic [7:0]       RX_DATA,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] GOOD,
  output logic [CNT_W-1:0] BAD,
  output logic [CNT_W-1:0] LOST
);

  localparam logic [CNT_W-1:0] MAXV   = '1;
  localparam logic [CNT_W-1:0] LAST_Q = CNT_W'(COUNT);

  state_t           r_state;
  logic [CNT_W-1:0] r_seq;
  logic [CNT_W-1:0] r_good;
  logic [CNT_W-1:0] r_bad;
  logic [CNT_W-1:0] r_lost;
  logic             r_tx_valid;
  logic [7:0]       r_tx_data;

  logic             w_tmr_clr;
  logic             w_tmr_en;
  logic             w_expire;
  logic [CNT_W-1:0] w_seq_nxt;
  logic             w_last;

  assign w_tmr_clr = (r_state == S_SEND) && TX_READY;
  assign w_tmr_en  = (r_state == S_WAIT_ECHO) && !RX_VALID;
  assign w_seq_nxt = r_seq + 1'b1;
  assign w_last    = (w_seq_nxt == LAST_Q);

  stress_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .i_clk    (SYSCLK),
    .i_rst    (SYSRST),
    .i_clr    (w_tmr_clr),
    .i_en     (w_tmr_en),
    .o_expire (w_expire)
  );

  always_ff @(posedge SYSCLK or posedge SYSRST) begin
    if (SYSRST) begin
      r_state    <= S_IDLE;
      r_seq      <= '0;
      r_good     <= '0;
      r_bad      <= '0;
      r_lost     <= '0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_tx_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (START) begin
            r_seq   <= '0;
            r_good  <= '0;
            r_bad   <= '0;
            r_lost  <= '0;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          // Nothing is outstanding here, so any received byte is stray.
          if (RX_VALID && (r_bad != MAXV)) r_bad <= r_bad + 1'b1;
          if (TX_READY) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= r_seq[7:0];
            r_state    <= S_WAIT_ECHO;
          end
        end
        S_WAIT_ECHO: begin
          if (RX_VALID || w_expire) begin
            if (RX_VALID) begin
              if (RX_DATA == r_seq[7:0]) begin
                if (r_good != MAXV) r_good <= r_good + 1'b1;
              end else begin
                if (r_bad != MAXV) r_bad <= r_bad + 1'b1;
              end
            end else if (r_lost != MAXV) begin
              r_lost <= r_lost + 1'b1;
            end
            r_seq   <= w_seq_nxt;
            r_state <= w_last ? S_DONE : S_SEND;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign TX_VALID = r_tx_valid;
  assign TX_DATA  = r_tx_data;
  assign BUSY     = (r_state == S_SEND) || (r_state == S_WAIT_ECHO);
  assign DONE     = (r_state == S_DONE);
  assign GOOD     = r_good;
  assign BAD      = r_bad;
  assign LOST     = r_lost;

endmodule

// File: tb/tb_uart_stress_gen.sv
// Directed bench: loopback, corrupt echo, timeout, stalls, stray bytes, reset and seq wrap.
module tb_uart_stress_gen;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, tx_ready, rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid, busy, done;
  logic [7:0]  tx_data;
  logic [15:0] good, bad, lost;

  logic        w_start, w_tx_ready, w_rx_valid;
  logic [7:0]  w_rx_data;
  logic        w_tx_valid, w_busy, w_done;
  logic [7:0]  w_tx_data;
  logic [15:0] w_good, w_bad, w_lost;

  int n_tests = 0;
  int n_fail  = 0;

  uart_stress_gen #(.COUNT(4), .CNT_W(16), .TIMEOUT(16)) u_dut (
    .SYSCLK(clk), .SYSRST(rst), .START(start), .TX_READY(tx_ready),
    .TX_VALID(tx_valid), .TX_DATA(tx_data), .RX_VALID(rx_valid), .RX_DATA(rx_data),
    .BUSY(busy), .DONE(done), .GOOD(good), .BAD(bad), .LOST(lost)
  );

  uart_stress_gen #(.COUNT(300), .CNT_W(16), .TIMEOUT(16)) u_wrap (
    .SYSCLK(clk), .SYSRST(rst), .START(w_start), .TX_READY(w_tx_ready),
    .TX_VALID(w_tx_valid), .TX_DATA(w_tx_data), .RX_VALID(w_rx_valid), .RX_DATA(w_rx_data),
    .BUSY(w_busy), .DONE(w_done), .GOOD(w_good), .BAD(w_bad), .LOST(w_lost)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Echo n bytes starting at index first, dly cycles after each TX_VALID; byte bad_i is corrupted.
  task automatic loopback(input int first, input int n, input int dly,
                          input int bad_i, input logic [7:0] bad_v);
    int to;
    for (int i = first; i < first + n; i++) begin
      to = 0;
      while (tx_valid !== 1'b1 && to < 200) begin
        tick();
        to++;
      end
      chk("tx_wait", 32'(to < 200), 1);
      chk("tx_data", 32'(tx_data), i & 255);
      for (int d = 0; d < dly; d++) begin
        tick();
        if (d == 0) chk("tx_pulse", 32'(tx_valid), 0);
      end
      rx_valid = 1'b1;
      rx_data  = (i == bad_i) ? bad_v : 8'(i);
      tick();
      rx_valid = 1'b0;
    end
  endtask

  initial begin
    int pulses;
    int to;
    int wrap_err;
    rst = 1'b1; start = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    w_start = 1'b0; w_tx_ready = 1'b1; w_rx_valid = 1'b0; w_rx_data = 8'h00;
    tick(); tick();
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cnts", 32'({good, bad | lost}), 0);
    rst = 1'b0;
    tick();

    // Perfect loopback, echo 10 cycles after each send
    tx_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 32'(busy), 1);
    loopback(0, 4, 10, -1, 8'h00);
    chk("p_done", 32'(done), 1);
    chk("p_busy", 32'(busy), 0);
    chk("p_good", 32'(good), 4);
    chk("p_bad", 32'(bad), 0);
    chk("p_lost", 32'(lost), 0);

    // Corrupt echo of byte 2, restart from DONE
    start = 1'b1;
    tick();
    start = 1'b0;
    loopback(0, 4, 10, 2, 8'hFF);
    chk("c_good", 32'(good), 3);
    chk("c_bad", 32'(bad), 1);
    chk("c_lost", 32'(lost), 0);
    chk("c_last_tx", 32'(tx_data), 3);

    // TX_READY stalled 50 cycles, then no echo at all
    tx_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("s_cleared", 32'({good, bad}), 0);
    pulses = 0;
    repeat (50) begin
      tick();
      pulses += int'(tx_valid);
    end
    chk("s_no_tx", 32'(pulses), 0);
    chk("s_no_lost", 32'(lost), 0);
    chk("s_busy", 32'(busy), 1);
    tx_ready = 1'b1;
    tick();
    chk("s_tx_next", 32'(tx_valid), 1);
    pulses = 1;
    repeat (66) begin
      tick();
      pulses += int'(tx_valid);
    end
    chk("t_not_done", 32'(done), 0);
    tick();
    pulses += int'(tx_valid);
    chk("t_done", 32'(done), 1);
    chk("t_lost", 32'(lost), 4);
    chk("t_good", 32'(good), 0);
    chk("t_pulses", 32'(pulses), 4);

    // Stray byte in SEND, then echo coinciding with expiry
    tx_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'h00;
    tick();
    rx_valid = 1'b0;
    chk("stray_bad", 32'(bad), 1);
    chk("stray_busy", 32'(busy), 1);
    tx_ready = 1'b1;
    tick();
    chk("x_tx", 32'(tx_valid), 1);
    repeat (15) tick();
    rx_valid = 1'b1;
    rx_data  = 8'h00;
    tick();
    rx_valid = 1'b0;
    chk("x_good", 32'(good), 1);
    chk("x_lost", 32'(lost), 0);
    loopback(1, 1, 3, -1, 8'h00);
    chk("x_good2", 32'(good), 2);

    // Reset mid-run, then a fresh run with same-cycle echoes
    rst = 1'b1;
    tick();
    chk("mr_tx_valid", 32'(tx_valid), 0);
    chk("mr_tx_data", 32'(tx_data), 0);
    chk("mr_cnts", 32'({good, bad | lost}), 0);
    chk("mr_state", 32'({busy, done}), 0);
    tick();
    chk("mr_tx_hold", 32'(tx_valid), 0);
    rst = 1'b0;
    tick();
    chk("mr_idle", 32'({busy, done}), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    loopback(0, 4, 0, -1, 8'h00);
    chk("r_done", 32'(done), 1);
    chk("r_good", 32'(good), 4);
    chk("r_bad_lost", 32'({bad, lost}), 0);

    // COUNT=300: sequence byte wraps 0xFF -> 0x00
    wrap_err = 0;
    w_start = 1'b1;
    tick();
    w_start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      to = 0;
      while (w_tx_valid !== 1'b1 && to < 50) begin
        tick();
        to++;
      end
      if (to >= 50) wrap_err++;
      if (i == 255 || i == 256) chk("wrap_edge", 32'(w_tx_data), i & 255);
      else if (w_tx_data !== 8'(i)) wrap_err++;
      w_rx_valid = 1'b1;
      w_rx_data  = w_tx_data;
      tick();
      w_rx_valid = 1'b0;
    end
    chk("wrap_seq", 32'(wrap_err), 0);
    chk("wrap_done", 32'(w_done), 1);
    chk("wrap_good", 32'(w_good), 300);
    chk("wrap_bad_lost", 32'({w_bad, w_lost}), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
